// File: rtl/irq_enc_pkg.sv
// Shared types and default sizing for the interrupt request encoder.
package irq_enc_pkg;

    localparam int unsigned IN_BITS = 4;
    localparam int unsigned N       = 1 << IN_BITS;

    typedef enum logic {IDLE, OFFER} state_t;

    typedef logic [N-1:0]       req_vec_t;
    typedef logic [IN_BITS-1:0] code_t;

endpackage

// File: rtl/priority_encoder_16_4.sv
// Combinational lowest-set-bit priority encoder; out is 0 when nothing is set.
module priority_encoder_16_4 #(
    parameter int unsigned IN_BITS = 4,
    localparam int unsigned N = 1 << IN_BITS
) (
    input  logic [N-1:0]       in,
    output logic [IN_BITS-1:0] out,
    output logic               hit
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        out = '0;
        hit = |in;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (in[i]) begin
                out = IN_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/irq_priority_encoder.sv
// Sticky request capture with lowest-index-first arbitration, offered as a
// binary code over a valid/ready handshake; the accepted index is cleared.
module irq_priority_encoder #(
    parameter int unsigned IN_BITS = irq_enc_pkg::IN_BITS,
    localparam int unsigned N = 1 << IN_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N-1:0]       req,
    input  logic [N-1:0]       mask,
    output logic [IN_BITS-1:0] code,
    output logic               valid,
    input  logic               ready,
    output logic [N-1:0]       pending,
    output logic               any_pend
);

    import irq_enc_pkg::state_t;
    import irq_enc_pkg::IDLE;
    import irq_enc_pkg::OFFER;

    state_t             state;
    logic               accept;
    logic [N-1:0]       clr;
    logic [N-1:0]       pending_nx;
    logic [N-1:0]       eligible;
    logic [N-1:0]       eligible_nx;
    logic [IN_BITS-1:0] winner;
    logic [IN_BITS-1:0] next_code;
    logic               win_hit;
    logic               next_hit;

    // New requests take precedence over the clear of the accepted index.
    always_comb begin
        accept = valid && ready;
        clr    = '0;
        if (accept) begin
            clr[code] = 1'b1;
        end
        pending_nx  = (pending & ~clr) | req;
        eligible    = pending & mask;
        eligible_nx = pending_nx & mask;
    end

    priority_encoder_16_4 #(.IN_BITS(IN_BITS)) u_winner (
        .in  (eligible),
        .out (winner),
        .hit (win_hit)
    );

    // Look-ahead winner lets an accept roll straight into the next offer.
    priority_encoder_16_4 #(.IN_BITS(IN_BITS)) u_next (
        .in  (eligible_nx),
        .out (next_code),
        .hit (next_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            code     <= '0;
            valid    <= 1'b0;
            any_pend <= 1'b0;
        end else begin
            pending  <= pending_nx;
            any_pend <= |eligible_nx;
            case (state)
                IDLE: begin
                    if (en && win_hit) begin
                        state <= OFFER;
                        code  <= winner;
                        valid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (accept) begin
                        if (en && next_hit) begin
                            code <= next_code;
                        end else begin
                            state <= IDLE;
                            valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Directed and randomized checks of irq_priority_encoder against a
// bit-array reference model of the capture/arbitration rules.
module tb_irq_priority_encoder;

    import irq_enc_pkg::req_vec_t;
    import irq_enc_pkg::code_t;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     en;
    req_vec_t req;
    req_vec_t mask;
    code_t    code;
    logic     valid;
    logic     ready;
    req_vec_t pending;
    logic     any_pend;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    req_vec_t m_pend;
    logic     m_valid;
    int       m_code;
    logic     m_any;

    irq_priority_encoder #(.IN_BITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req      (req),
        .mask     (mask),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .any_pend (any_pend)
    );

    always #5 clk = ~clk;

    function automatic int lowest(input req_vec_t v);
        for (int i = 0; i < 16; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Downstream 4-to-16 decoder enabled by valid.
    function automatic req_vec_t decode_4_16(input logic e, input code_t c);
        req_vec_t one;
        one = 16'd1;
        return e ? (one << c) : 16'd0;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = 0;
        m_any   = 1'b0;
    endtask

    // Advance model and DUT by one clock; inputs must already be applied.
    task automatic tick();
        req_vec_t np;
        logic     nv;
        int       nc;
        int       w;
        np = m_pend;
        nv = m_valid;
        nc = m_code;
        if (m_valid && ready) np[m_code] = 1'b0;
        np = np | req;
        if (!m_valid) begin
            w = lowest(m_pend & mask);
            if (en && w >= 0) begin
                nv = 1'b1;
                nc = w;
            end
        end else if (ready) begin
            w = lowest(np & mask);
            if (en && w >= 0) nc = w;
            else nv = 1'b0;
        end
        @(posedge clk);
        #1;
        m_pend  = np;
        m_valid = nv;
        m_code  = nc;
        m_any   = ((np & mask) != 16'd0);
    endtask

    task automatic set_in(input logic e, input req_vec_t r, input req_vec_t m, input logic rd);
        en    = e;
        req   = r;
        mask  = m;
        ready = rd;
    endtask

    task automatic test_reset();
        set_in(1'b0, 16'h0, 16'hFFFF, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if (pending !== 16'h0 || valid !== 1'b0 || code !== 4'd0 || any_pend !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init pend=%h valid=%b code=%0d any=%b want 0/0/0/0", pending, valid, code, any_pend);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Fill everything, offer index 8 (lower half masked), then reset mid-offer.
        set_in(1'b1, 16'hFFFF, 16'hFF00, 1'b0);
        tick();
        req = 16'h0;
        tick();
        n_vec++;
        if (pending !== 16'hFFFF || valid !== 1'b1 || code !== 4'd8) begin
            n_err++;
            $display("FAIL reset_prefill pend=%h valid=%b code=%0d want ffff/1/8", pending, valid, code);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (pending !== 16'h0 || valid !== 1'b0 || code !== 4'd0 || any_pend !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async pend=%h valid=%b code=%0d any=%b want 0/0/0/0", pending, valid, code, any_pend);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_in(1'b1, 16'h0, 16'hFFFF, 1'b1);
    endtask

    task automatic test_single();
        set_in(1'b1, 16'h0100, 16'hFFFF, 1'b1);
        tick();
        req = 16'h0;
        n_vec++;
        if (pending !== 16'h0100 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_capture pend=%h valid=%b want 0100/0", pending, valid);
        end
        tick();
        n_vec++;
        if (valid !== 1'b1 || code !== 4'd8) begin
            n_err++;
            $display("FAIL single_offer valid=%b code=%0d want 1/8", valid, code);
        end
        tick();
        n_vec++;
        if (valid !== 1'b0 || pending !== 16'h0) begin
            n_err++;
            $display("FAIL single_accept valid=%b pend=%h want 0/0000", valid, pending);
        end
    endtask

    task automatic test_back_to_back();
        int exp_codes [4] = '{0, 5, 10, 15};
        set_in(1'b1, 16'h8421, 16'hFFFF, 1'b1);
        tick();
        req = 16'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if (valid !== 1'b1 || code !== 4'(exp_codes[k])) begin
                n_err++;
                $display("FAIL b2b_code%0d valid=%b code=%0d want 1/%0d", k, valid, code, exp_codes[k]);
            end
        end
        tick();
        n_vec++;
        if (valid !== 1'b0 || pending !== 16'h0) begin
            n_err++;
            $display("FAIL b2b_end valid=%b pend=%h want 0/0000", valid, pending);
        end
    endtask

    task automatic test_stall();
        set_in(1'b1, 16'h0008, 16'hFFFF, 1'b0);
        tick();
        req = 16'h0;
        tick();
        for (int k = 0; k < 5; k++) begin
            req = (k % 2 == 0) ? 16'h0002 : 16'h0000;
            tick();
            n_vec++;
            if (valid !== 1'b1 || code !== 4'd3) begin
                n_err++;
                $display("FAIL stall_hold%0d valid=%b code=%0d want 1/3", k, valid, code);
            end
        end
        req   = 16'h0;
        ready = 1'b1;
        tick();
        n_vec++;
        if (valid !== 1'b1 || code !== 4'd1 || pending !== 16'h0002) begin
            n_err++;
            $display("FAIL stall_next valid=%b code=%0d pend=%h want 1/1/0002", valid, code, pending);
        end
        tick();
        n_vec++;
        if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_end valid=%b want 0", valid);
        end
    endtask

    task automatic test_mask_en();
        set_in(1'b1, 16'h0010, 16'h0000, 1'b1);
        tick();
        req = 16'h0;
        tick();
        tick();
        n_vec++;
        if (valid !== 1'b0 || any_pend !== 1'b0 || pending !== 16'h0010) begin
            n_err++;
            $display("FAIL mask_all valid=%b any=%b pend=%h want 0/0/0010", valid, any_pend, pending);
        end
        mask = 16'h0010;
        en   = 1'b0;
        tick();
        tick();
        n_vec++;
        if (valid !== 1'b0 || any_pend !== 1'b1) begin
            n_err++;
            $display("FAIL en_low valid=%b any=%b want 0/1", valid, any_pend);
        end
        en = 1'b1;
        tick();
        n_vec++;
        if (valid !== 1'b1 || code !== 4'd4) begin
            n_err++;
            $display("FAIL en_high valid=%b code=%0d want 1/4", valid, code);
        end
        mask = 16'hFFFF;
        tick();
        n_vec++;
        if (valid !== 1'b0 || pending !== 16'h0) begin
            n_err++;
            $display("FAIL mask_drain valid=%b pend=%h want 0/0000", valid, pending);
        end
    endtask

    task automatic test_set_clear();
        set_in(1'b1, 16'h0004, 16'hFFFF, 1'b0);
        tick();
        req = 16'h0;
        tick();
        req   = 16'h0004;
        ready = 1'b1;
        tick();
        req = 16'h0;
        n_vec++;
        if (pending !== 16'h0004 || valid !== 1'b1 || code !== 4'd2) begin
            n_err++;
            $display("FAIL setclr_reoffer pend=%h valid=%b code=%0d want 0004/1/2", pending, valid, code);
        end
        tick();
        n_vec++;
        if (pending !== 16'h0 || valid !== 1'b0) begin
            n_err++;
            $display("FAIL setclr_end pend=%h valid=%b want 0000/0", pending, valid);
        end
    endtask

    task automatic test_round_trip();
        req_vec_t one;
        one = 16'd1;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, one << i, 16'hFFFF, 1'b1);
            tick();
            req = 16'h0;
            tick();
            n_vec++;
            if (decode_4_16(valid, code) !== (one << i)) begin
                n_err++;
                $display("FAIL roundtrip%0d dec=%h want %h", i, decode_4_16(valid, code), one << i);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            en    = ($urandom_range(0, 7) != 0);
            ready = ($urandom_range(0, 3) != 0);
            req   = 16'($urandom) & 16'($urandom) & 16'($urandom);
            mask  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            tick();
            n_vec++;
            if (valid !== m_valid || code !== 4'(m_code) || pending !== m_pend || any_pend !== m_any) begin
                n_err++;
                $display("FAIL random%0d valid=%b code=%0d pend=%h any=%b want %b/%0d/%h/%b",
                         k, valid, code, pending, any_pend, m_valid, m_code, m_pend, m_any);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_mask_en();
        test_set_clear();
        test_round_trip();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
